// File: rtl/moore_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : moore_pattern_detector
// Description : Moore serial pattern detector with runtime pattern, overlap
//               mode, sample enable, arm/disarm and saturating hit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module moore_pattern_detector #(
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               din,
   input  logic               load,
   input  logic               stop,
   input  logic               overlap,
   input  logic [PAT_LEN-1:0] pattern,
   output logic               qout,
   output logic [1:0]         state,
   output logic [CNT_W-1:0]   hit_cnt
);

   localparam int c_fill_w = $clog2(PAT_LEN + 1);
   localparam logic [c_fill_w-1:0] c_full = c_fill_w'(PAT_LEN);
   localparam logic [c_fill_w-1:0] c_one  = c_fill_w'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FILL  = 2'b01,
      S_RUN   = 2'b10,
      S_MATCH = 2'b11
   } state_t;

   state_t               r_state;
   logic                 r_qout;
   logic [CNT_W-1:0]     r_cnt;
   logic [PAT_LEN-1:0]   r_win;
   logic [PAT_LEN-1:0]   r_pat;
   logic [c_fill_w-1:0]  r_fill;

   state_t               w_nxt_state;
   logic [PAT_LEN-1:0]   w_nxt_win;
   logic [c_fill_w-1:0]  w_nxt_fill;
   logic [PAT_LEN-1:0]   w_shift;
   logic [c_fill_w-1:0]  w_fill_inc;
   logic                 w_hit;
   logic                 w_sample;

   assign w_shift    = {r_win[PAT_LEN-2:0], din};
   assign w_fill_inc = r_fill + 1'b1;
   assign w_hit      = (w_shift == r_pat);
   assign w_sample   = en && (r_state != S_IDLE);

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_win   = r_win;
      w_nxt_fill  = r_fill;
      if (w_sample) begin
         case (r_state)
            S_FILL: begin
               w_nxt_win  = w_shift;
               w_nxt_fill = w_fill_inc;
               if (w_fill_inc == c_full)
                  w_nxt_state = w_hit ? S_MATCH : S_RUN;
               else
                  w_nxt_state = S_FILL;
            end
            S_RUN: begin
               w_nxt_win   = w_shift;
               w_nxt_state = w_hit ? S_MATCH : S_RUN;
            end
            S_MATCH: begin
               if (overlap) begin
                  w_nxt_win   = w_shift;
                  w_nxt_state = w_hit ? S_MATCH : S_RUN;
               end else begin
                  // Non-overlap: the bit sampled here opens the next window
                  w_nxt_win   = {{(PAT_LEN-1){1'b0}}, din};
                  w_nxt_fill  = c_one;
                  w_nxt_state = S_FILL;
               end
            end
            default: w_nxt_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_qout  <= 1'b0;
         r_cnt   <= '0;
         r_win   <= '0;
         r_fill  <= '0;
         r_pat   <= '0;
      end else if (stop) begin
         r_state <= S_IDLE;
         r_qout  <= 1'b0;
         r_win   <= '0;
         r_fill  <= '0;
      end else if (load) begin
         r_pat   <= pattern;
         r_state <= S_FILL;
         r_qout  <= 1'b0;
         r_cnt   <= '0;
         r_win   <= '0;
         r_fill  <= '0;
      end else if (w_sample) begin
         r_state <= w_nxt_state;
         r_qout  <= (w_nxt_state == S_MATCH);
         r_win   <= w_nxt_win;
         r_fill  <= w_nxt_fill;
         if ((w_nxt_state == S_MATCH) && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign qout    = r_qout;
   assign state   = r_state;
   assign hit_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_moore_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_moore_pattern_detector
// Description : Directed and random checks of moore_pattern_detector against
//               a bit-history reference model (CNT_W=8 and CNT_W=2 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moore_pattern_detector;

   localparam int P = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         en, din, load, stop, overlap;
   logic [P-1:0] pattern;
   logic         qout8, qout2;
   logic [1:0]   state8, state2;
   logic [7:0]   hit8;
   logic [1:0]   hit2;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: bits sampled since the current window opened
   bit           m_armed;
   bit           m_match;
   bit           m_q[$];
   logic [P-1:0] m_pat;
   int           m_cnt;

   moore_pattern_detector #(.PAT_LEN(P), .CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .en(en), .din(din), .load(load), .stop(stop),
      .overlap(overlap), .pattern(pattern), .qout(qout8), .state(state8),
      .hit_cnt(hit8)
   );

   moore_pattern_detector #(.PAT_LEN(P), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .din(din), .load(load), .stop(stop),
      .overlap(overlap), .pattern(pattern), .qout(qout2), .state(state2),
      .hit_cnt(hit2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_armed = 0; m_match = 0; m_q.delete(); m_pat = '0; m_cnt = 0;
   endtask

   function automatic bit tail_matches();
      int n = m_q.size();
      if (n < P) return 0;
      for (int i = 0; i < P; i++)
         if (m_q[n-P+i] != m_pat[P-1-i]) return 0;
      return 1;
   endfunction

   task automatic model_edge();
      if (stop) begin
         m_armed = 0; m_match = 0; m_q.delete();
      end else if (load) begin
         m_pat = pattern; m_q.delete(); m_cnt = 0; m_armed = 1; m_match = 0;
      end else if (en && m_armed) begin
         if (m_match && !overlap) m_q.delete();
         m_q.push_back(din);
         if (m_q.size() > P) void'(m_q.pop_front());
         m_match = tail_matches();
         if (m_match) m_cnt++;
      end
   endtask

   task automatic compare_all(input string tag);
      logic [1:0] es;
      if (!m_armed)             es = 2'b00;
      else if (m_match)         es = 2'b11;
      else if (m_q.size() < P)  es = 2'b01;
      else                      es = 2'b10;
      check({tag, ".state"}, 32'(state8), 32'(es));
      check({tag, ".qout"},  32'(qout8),  32'(m_match));
      check({tag, ".hit8"},  32'(hit8),   32'((m_cnt > 255) ? 255 : m_cnt));
      check({tag, ".hit2"},  32'(hit2),   32'((m_cnt > 3) ? 3 : m_cnt));
      check({tag, ".qout2"}, 32'(qout2),  32'(m_match));
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      compare_all(tag);
      en = 0; load = 0; stop = 0;
   endtask

   task automatic do_load(input logic [P-1:0] p, input string tag);
      load = 1; pattern = p; din = $urandom_range(0, 1);
      cyc(tag);
   endtask

   task automatic sample(input bit b, input string tag);
      en = 1; din = b;
      cyc(tag);
   endtask

   bit stream[7] = '{1, 0, 1, 1, 0, 1, 1};

   initial begin
      rst = 1; en = 0; din = 0; load = 0; stop = 0; overlap = 1; pattern = '0;
      model_reset();
      #2;
      compare_all("reset");
      #10 rst = 0;

      // Overlapping detection of 1011
      overlap = 1;
      do_load(4'b1011, "t2.load");
      check("t2.load_state", 32'(state8), 32'h1);
      foreach (stream[i]) sample(stream[i], "t2");
      check("t2.final_hit", 32'(hit8), 32'd2);
      check("t2.final_q", 32'(qout8), 32'd1);

      // Non-overlapping: window restarts after the first match
      overlap = 0;
      do_load(4'b1011, "t3.load");
      foreach (stream[i]) sample(stream[i], "t3");
      check("t3.final_hit", 32'(hit8), 32'd1);
      check("t3.final_state", 32'(state8), 32'h1);

      // Same stream with idle gaps and noisy din
      overlap = 1;
      do_load(4'b1011, "t4.load");
      foreach (stream[i]) begin
         sample(stream[i], "t4");
         for (int g = 0; g < 3; g++) begin
            en = 0; din = $urandom_range(0, 1);
            cyc("t4.gap");
         end
      end
      check("t4.final_hit", 32'(hit8), 32'd2);

      // Saturation of the 2-bit counter
      do_load(4'b1111, "t5.load");
      for (int i = 0; i < 8; i++) sample(1'b1, "t5");
      check("t5.hit2_sat", 32'(hit2), 32'd3);
      check("t5.hit8", 32'(hit8), 32'd5);

      // Asynchronous reset mid-cycle while in MATCH
      check("t1.in_match", 32'(state8), 32'h3);
      #3 rst = 1;
      #1;
      model_reset();
      compare_all("t1.async");
      #1 rst = 0;

      // Reload while in RUN, then stop while in MATCH
      overlap = 1;
      do_load(4'b1011, "t6.load1");
      for (int i = 0; i < 4; i++) sample(1'b0, "t6.fill");
      check("t6.in_run", 32'(state8), 32'h2);
      do_load(4'b0000, "t6.load2");
      check("t6.reload_state", 32'(state8), 32'h1);
      check("t6.reload_hit", 32'(hit8), 32'd0);
      for (int i = 0; i < 4; i++) sample(1'b0, "t6.zeros");
      check("t6.match", 32'(qout8), 32'd1);
      stop = 1; en = 1; din = 0;
      cyc("t6.stop");
      check("t6.idle", 32'(state8), 32'h0);
      for (int i = 0; i < 6; i++) sample(1'b0, "t6.ignored");

      // Randomized traffic
      do_load(4'(($urandom_range(0, 3) == 0) ? 4'b0000 : $urandom_range(0, 15)), "rnd.load");
      for (int i = 0; i < 400; i++) begin
         en      = ($urandom_range(0, 3) != 0);
         din     = $urandom_range(0, 1);
         overlap = $urandom_range(0, 1);
         load    = ($urandom_range(0, 39) == 0);
         stop    = ($urandom_range(0, 79) == 0);
         pattern = 4'($urandom_range(0, 15));
         cyc("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
